// File: rtl/erx_deframer.sv
// eLink receive deframer: finds packet starts on any byte lane, assembles 104-bit
// transactions and queues them in a small FIFO. Define ERX_DEFRAMER_BURST_EN for burst beats.
module erx_deframer #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned WAIT_THRESH = 2
) (
  input  logic         rx_lclk_div4,
  input  logic         nreset,
  input  logic [7:0]   rx_frame_par,
  input  logic [63:0]  rx_data_par,
  output logic         out_access,
  output logic [103:0] out_packet,
  input  logic         out_wait,
  output logic         rx_wr_wait,
  output logic [7:0]   err_count
);

  localparam int unsigned PKT_W     = 104;
  localparam int unsigned AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW        = AW + 1;
  localparam int unsigned HDR_BYTES = 13;
`ifdef ERX_DEFRAMER_BURST_EN
  localparam int unsigned BEAT_BYTES = 8;
`endif

  typedef enum logic [1:0] {IDLE, COLLECT, TAIL} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [PKT_W-1:0] shreg_q, shreg_d;
  logic [7:0]       frame_q;
  logic [63:0]      data_q;
  logic             prev_frame_q;
  logic [8:0]       fr_c;
  logic [7:0]       byte_c;
  logic             push_c;
  logic [PKT_W-1:0] push_pkt_c;
  logic [3:0]       err_inc_c;
`ifdef ERX_DEFRAMER_BURST_EN
  logic [7:0]       ctrl_q, ctrl_d;
  logic [31:0]      dst_q, dst_d;
`endif

  // Frame bits with the last lane of the previous word prepended (lane 8 = preceding byte of lane 7)
  assign fr_c = {prev_frame_q, frame_q};

  // Per-byte FSM, unrolled over lanes 7 (earliest) down to 0
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    byte_c     = '0;
    push_c     = 1'b0;
    push_pkt_c = '0;
    err_inc_c  = '0;
`ifdef ERX_DEFRAMER_BURST_EN
    ctrl_d     = ctrl_q;
    dst_d      = dst_q;
`endif
    for (int i = 7; i >= 0; i--) begin
      byte_c = data_q[8*i +: 8];
      case (state_d)
        IDLE: begin
          if (fr_c[i] && !fr_c[i+1]) begin
            shreg_d = {shreg_d[PKT_W-9:0], byte_c};
            cnt_d   = 4'd1;
            state_d = COLLECT;
          end
        end
        COLLECT: begin
          if (fr_c[i]) begin
            shreg_d = {shreg_d[PKT_W-9:0], byte_c};
            if (cnt_d == 4'(HDR_BYTES - 1)) begin
              // Stream order is ctrl, dst, data, src (MSB first); output packs src at the top
              push_c     = 1'b1;
              push_pkt_c = {shreg_d[31:0], shreg_d[63:32], shreg_d[95:64], shreg_d[103:96]};
`ifdef ERX_DEFRAMER_BURST_EN
              ctrl_d     = shreg_d[103:96];
              dst_d      = shreg_d[95:64];
`endif
              cnt_d      = '0;
              state_d    = TAIL;
            end else begin
              cnt_d = cnt_d + 4'd1;
            end
          end else begin
            err_inc_c = err_inc_c + 4'd1;
            cnt_d     = '0;
            state_d   = IDLE;
          end
        end
        TAIL: begin
          if (fr_c[i]) begin
`ifdef ERX_DEFRAMER_BURST_EN
            shreg_d = {shreg_d[PKT_W-9:0], byte_c};
            if (cnt_d == 4'(BEAT_BYTES - 1)) begin
              dst_d      = dst_d + 32'd8;
              push_c     = 1'b1;
              push_pkt_c = {shreg_d[31:0], shreg_d[63:32], dst_d, ctrl_d};
              cnt_d      = '0;
            end else begin
              cnt_d = cnt_d + 4'd1;
            end
`else
            // cnt doubles as an "overstay already counted" flag
            if (cnt_d == 4'd0) begin
              err_inc_c = err_inc_c + 4'd1;
              cnt_d     = 4'd1;
            end
`endif
          end else begin
`ifdef ERX_DEFRAMER_BURST_EN
            if (cnt_d != 4'd0) err_inc_c = err_inc_c + 4'd1;
`endif
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Input word register and deframer state
  always_ff @(posedge rx_lclk_div4 or negedge nreset) begin
    if (!nreset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      frame_q      <= '0;
      data_q       <= '0;
      prev_frame_q <= 1'b0;
`ifdef ERX_DEFRAMER_BURST_EN
      ctrl_q       <= '0;
      dst_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      frame_q      <= rx_frame_par;
      data_q       <= rx_data_par;
      prev_frame_q <= frame_q[0];
`ifdef ERX_DEFRAMER_BURST_EN
      ctrl_q       <= ctrl_d;
      dst_q        <= dst_d;
`endif
    end
  end

  logic [PKT_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_c, full_c, wr_c, drop_c;
  logic [PKT_W-1:0] head_c;
  logic [8:0]       err_sum_c;
  logic [7:0]       err_d;

  assign pop_c     = out_access && !out_wait;
  assign full_c    = (count_q == CW'(FIFO_DEPTH));
  assign wr_c      = push_c && (!full_c || pop_c);
  assign drop_c    = push_c && full_c && !pop_c;
  assign rd_ptr_d  = pop_c ? rd_ptr_q + AW'(1) : rd_ptr_q;
  assign count_d   = count_q + CW'(wr_c) - CW'(pop_c);
  assign err_sum_c = 9'(err_count) + 9'(err_inc_c) + 9'(drop_c);
  assign err_d     = err_sum_c[8] ? 8'hFF : err_sum_c[7:0];

  // Next head: bypass the entry being written when it lands at the new read pointer
  always_comb begin
    head_c = mem_q[rd_ptr_d];
    if (wr_c && (wr_ptr_q == rd_ptr_d)) head_c = push_pkt_c;
  end

  always_ff @(posedge rx_lclk_div4) begin
    if (wr_c) mem_q[wr_ptr_q] <= push_pkt_c;
  end

  // FIFO pointers and registered outputs
  always_ff @(posedge rx_lclk_div4 or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_access <= 1'b0;
      out_packet <= '0;
      rx_wr_wait <= 1'b0;
      err_count  <= '0;
    end else begin
      if (wr_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out_access <= (count_d != '0);
      if (count_d != '0) out_packet <= head_c;
      rx_wr_wait <= (count_q >= CW'(WAIT_THRESH));
      err_count  <= err_d;
    end
  end

endmodule

// File: tb/tb_erx_deframer.sv
// Scoreboard bench for erx_deframer: packets are described by fields, serialized
// to a framed byte stream, and expected transactions are queued as they are issued.
module tb_erx_deframer;

  logic         rx_lclk_div4 = 1'b0;
  logic         nreset = 1'b0;
  logic [7:0]   rx_frame_par = '0;
  logic [63:0]  rx_data_par = '0;
  logic         out_access;
  logic [103:0] out_packet;
  logic         out_wait = 1'b0;
  logic         rx_wr_wait;
  logic [7:0]   err_count;

  erx_deframer #(.FIFO_DEPTH(4), .WAIT_THRESH(2)) dut (
    .rx_lclk_div4 (rx_lclk_div4),
    .nreset       (nreset),
    .rx_frame_par (rx_frame_par),
    .rx_data_par  (rx_data_par),
    .out_access   (out_access),
    .out_packet   (out_packet),
    .out_wait     (out_wait),
    .rx_wr_wait   (rx_wr_wait),
    .err_count    (err_count)
  );

  always #5 rx_lclk_div4 = ~rx_lclk_div4;

  int             total = 0;
  int             bad = 0;
  int             err_exp = 0;
  logic [103:0]   exp_q[$];
  logic [8:0]     stream_q[$];

  task automatic check(input string name, input logic [103:0] act, input logic [103:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic err_inc();
    if (err_exp < 255) err_exp++;
  endtask

  task automatic put_byte(input logic f, input logic [7:0] b);
    stream_q.push_back({f, b});
  endtask

  task automatic put_w32(input logic [31:0] w);
    for (int j = 3; j >= 0; j--) put_byte(1'b1, w[8*j +: 8]);
  endtask

  task automatic add_gap(input int n);
    for (int j = 0; j < n; j++) put_byte(1'b0, 8'($urandom));
  endtask

  // Header packet plus 'tail' extra framed bytes; keep=0 means the FIFO is expected to drop it
  task automatic add_packet(input logic [7:0] ctrl, input logic [31:0] dst, input logic [31:0] data,
                            input logic [31:0] src, input int tail, input int gap, input bit keep);
    int nb;
    int rem;
    logic [31:0] bd;
    logic [31:0] bs;
    put_byte(1'b1, ctrl);
    put_w32(dst);
    put_w32(data);
    put_w32(src);
    if (keep) exp_q.push_back({src, data, dst, ctrl});
    else err_inc();
    nb  = tail / 8;
    rem = tail % 8;
    for (int k = 0; k < nb; k++) begin
      bd = $urandom;
      bs = $urandom;
      put_w32(bd);
      put_w32(bs);
`ifdef ERX_DEFRAMER_BURST_EN
      exp_q.push_back({bs, bd, dst + 32'(8 * (k + 1)), ctrl});
`endif
    end
    for (int k = 0; k < rem; k++) put_byte(1'b1, 8'($urandom));
`ifdef ERX_DEFRAMER_BURST_EN
    if (rem != 0) err_inc();
`else
    if (tail > 0) err_inc();
`endif
    add_gap(gap);
  endtask

  task automatic add_trunc(input int n, input int gap);
    for (int k = 0; k < n; k++) put_byte(1'b1, 8'($urandom));
    err_inc();
    add_gap(gap);
  endtask

  task automatic drive_word(input logic [7:0] f, input logic [63:0] d);
    @(posedge rx_lclk_div4);
    #1;
    rx_frame_par = f;
    rx_data_par  = d;
  endtask

  // Lane 7 carries the earliest byte; a short last word is padded with unframed bytes
  task automatic flush(input int idle_words);
    logic [7:0]  f;
    logic [63:0] d;
    logic [8:0]  e;
    while (stream_q.size() > 0) begin
      f = '0;
      d = '0;
      for (int l = 7; l >= 0; l--) begin
        if (stream_q.size() > 0) begin
          e = stream_q.pop_front();
          f[l] = e[8];
          d[8*l +: 8] = e[7:0];
        end
      end
      drive_word(f, d);
    end
    for (int k = 0; k < idle_words; k++) drive_word(8'h00, 64'h0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive_word(8'h00, 64'h0);
  endtask

  // Monitor: every accepted head must match the oldest expected transaction
  initial begin
    forever begin
      @(negedge rx_lclk_div4);
      if (nreset && out_access && !out_wait) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pkt: got %h expected none", out_packet);
        end else begin
          check("pkt", out_packet, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge rx_lclk_div4);
    nreset = 1'b1;
    @(negedge rx_lclk_div4);
    check("rst_access", 104'(out_access), 104'(1'b0));
    check("rst_packet", out_packet, 104'h0);
    check("rst_wr_wait", 104'(rx_wr_wait), 104'(1'b0));
    check("rst_err", 104'(err_count), 104'(8'd0));

    // Aligned packet: two words exactly, then latency of the head-valid
    idle(2);
    add_packet(8'h02, 32'h80000010, 32'hDEADBEEF, 32'h01234567, 0, 3, 1'b1);
    flush(0);
    drive_word(8'h00, 64'h0);
    check("lat_n1", 104'(out_access), 104'(1'b0));
    drive_word(8'h00, 64'h0);
    check("lat_n2", 104'(out_access), 104'(1'b1));
    idle(4);
    check("aligned_err", 104'(err_count), 104'(err_exp));

    // Misaligned start at lane 2, spanning three words
    add_gap(5);
    add_packet(8'h02, 32'h80000010, 32'hDEADBEEF, 32'h89ABCDEF, 0, 4, 1'b1);
    flush(4);
    check("misaligned_err", 104'(err_count), 104'(err_exp));

    // Truncated after 9 bytes
    add_trunc(9, 3);
    flush(4);
    check("trunc_err", 104'(err_count), 104'(err_exp));

    // Header followed by two full beats of framed data
    add_packet(8'h05, 32'h00001000, $urandom, $urandom, 16, 2, 1'b1);
    flush(6);
    check("burst_err", 104'(err_count), 104'(err_exp));
    check("burst_drained", 104'(exp_q.size()), 104'(0));

    // Backpressure: stall the consumer, fill the FIFO, overflow once
    @(posedge rx_lclk_div4);
    #1 out_wait = 1'b1;
    add_packet(8'h11, $urandom, $urandom, $urandom, 0, 2, 1'b1);
    flush(4);
    check("bp_wait_1", 104'(rx_wr_wait), 104'(1'b0));
    check("bp_access", 104'(out_access), 104'(1'b1));
    add_packet(8'h12, $urandom, $urandom, $urandom, 0, 2, 1'b1);
    flush(4);
    check("bp_wait_2", 104'(rx_wr_wait), 104'(1'b1));
    add_packet(8'h13, $urandom, $urandom, $urandom, 0, 2, 1'b1);
    add_packet(8'h14, $urandom, $urandom, $urandom, 0, 2, 1'b1);
    add_packet(8'h15, $urandom, $urandom, $urandom, 0, 2, 1'b0);
    flush(4);
    check("bp_head_stable", out_packet, exp_q[0]);
    check("bp_wait_full", 104'(rx_wr_wait), 104'(1'b1));
    check("bp_overflow_err", 104'(err_count), 104'(err_exp));
    @(posedge rx_lclk_div4);
    #1 out_wait = 1'b0;
    idle(10);
    check("bp_drained", 104'(exp_q.size()), 104'(0));
    check("bp_wait_clear", 104'(rx_wr_wait), 104'(1'b0));
    check("bp_access_clear", 104'(out_access), 104'(1'b0));

    // Random mix of packets, truncations and overlong/burst tails at random lane offsets
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) < 2) begin
        add_trunc($urandom_range(1, 12), $urandom_range(1, 9));
      end else begin
        add_packet(8'($urandom), $urandom, $urandom, $urandom,
                   ($urandom_range(0, 9) < 3) ? $urandom_range(1, 20) : 0,
                   $urandom_range(1, 9), 1'b1);
      end
      if (n % 10 == 9) flush(2);
    end
    flush(8);
    check("rand_err", 104'(err_count), 104'(err_exp));
    check("rand_drained", 104'(exp_q.size()), 104'(0));

    // Reset in the middle of a packet with two entries queued
    @(posedge rx_lclk_div4);
    #1 out_wait = 1'b1;
    add_packet(8'h21, $urandom, $urandom, $urandom, 0, 2, 1'b1);
    add_packet(8'h22, $urandom, $urandom, $urandom, 0, 2, 1'b1);
    flush(4);
    check("pre_rst_access", 104'(out_access), 104'(1'b1));
    check("pre_rst_wait", 104'(rx_wr_wait), 104'(1'b1));
    drive_word(8'hFF, {$urandom, $urandom});
    drive_word(8'h00, 64'h0);
    @(posedge rx_lclk_div4);
    #2 nreset = 1'b0;
    #1;
    check("mid_rst_access", 104'(out_access), 104'(1'b0));
    check("mid_rst_packet", out_packet, 104'h0);
    check("mid_rst_wait", 104'(rx_wr_wait), 104'(1'b0));
    check("mid_rst_err", 104'(err_count), 104'(8'd0));
    exp_q.delete();
    err_exp = 0;
    out_wait = 1'b0;
    repeat (3) @(negedge rx_lclk_div4);
    nreset = 1'b1;
    idle(2);
    add_packet(8'h33, $urandom, $urandom, $urandom, 0, 3, 1'b1);
    flush(6);
    check("post_rst_err", 104'(err_count), 104'(err_exp));
    check("post_rst_drained", 104'(exp_q.size()), 104'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
